// File: rtl/fnd_bcd_counter_if.sv
// Control/count bundle for fnd_bcd_counter.
//   en, up, clksel, load, load_bcd : driven by the controller (master)
//   bcd_value, wrap                : driven by the counter (slave)
// The seg/an pins stay as plain ports on the counter because they go straight to the board.
interface fnd_bcd_counter_if #(
    parameter int unsigned NUM_DIGITS = 8
);
    logic                    en;
    logic                    up;
    logic                    clksel;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] load_bcd;
    logic [4*NUM_DIGITS-1:0] bcd_value;
    logic                    wrap;

    modport master (
        output en, up, clksel, load, load_bcd,
        input  bcd_value, wrap
    );

    modport slave (
        input  en, up, clksel, load, load_bcd,
        output bcd_value, wrap
    );
endinterface

// File: rtl/fnd_bcd_counter.sv
// Multi-digit packed-BCD up/down counter with a time-multiplexed active-low 7-segment driver.
//
// Ports:
//   clk  - system clock
//   rst  - synchronous reset, active-high
//   bus  - fnd_bcd_counter_if.slave: en, up, clksel, load, load_bcd in; bcd_value, wrap out
//   seg  - segment pattern {g,f,e,d,c,b,a}, active-low, registered
//   an   - digit enables, active-low one-hot, registered
//
// Optional feature: define FND_LZB_EN to blank leading zeros (digit 0 is always shown).
module fnd_bcd_counter #(
    parameter int unsigned NUM_DIGITS    = 8,
    parameter int unsigned TICK_DIV      = 1000000,
    parameter int unsigned TICK_DIV_FAST = 500000,
    parameter int unsigned REFRESH_DIV   = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    fnd_bcd_counter_if.slave      bus,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an
);
    localparam int unsigned W        = 4 * NUM_DIGITS;
    localparam int unsigned TICK_MAX = (TICK_DIV > TICK_DIV_FAST) ? TICK_DIV : TICK_DIV_FAST;
    localparam int unsigned PW       = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
    localparam int unsigned RW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PW-1:0] PSLOW = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PFAST = PW'(TICK_DIV_FAST - 1);
    localparam logic [RW-1:0] RLAST = RW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] ILAST = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]         presc_q, presc_d;
    logic                  step;
    logic [W-1:0]          bcd_q, bcd_d;
    logic                  wrap_q, wrap_d;
    logic [RW-1:0]         ref_q, ref_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b1000000;
            4'd1:    seg_code = 7'b1111001;
            4'd2:    seg_code = 7'b0100100;
            4'd3:    seg_code = 7'b0110000;
            4'd4:    seg_code = 7'b0011001;
            4'd5:    seg_code = 7'b0010010;
            4'd6:    seg_code = 7'b0000010;
            4'd7:    seg_code = 7'b1111000;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0010000;
            default: seg_code = 7'b1111111;
        endcase
    endfunction

    // Prescaler: >= rather than == so a switch to the shorter period mid-count still steps.
    always_comb begin
        step    = 1'b0;
        presc_d = presc_q;
        if (bus.en) begin
            if (presc_q >= (bus.clksel ? PFAST : PSLOW)) begin
                step    = 1'b1;
                presc_d = '0;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
        if (bus.load) begin
            presc_d = '0;
        end
    end

    // Ripple carry/borrow across digits; a carry out of the top digit is exactly the wrap case.
    always_comb begin
        logic [3:0] dig;
        logic       carry;
        bcd_d  = bcd_q;
        wrap_d = 1'b0;
        carry  = 1'b1;
        dig    = '0;
        if (bus.load) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                dig             = bus.load_bcd[4*i +: 4];
                bcd_d[4*i +: 4] = (dig > 4'd9) ? 4'd0 : dig;
            end
        end else if (step) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                dig = bcd_q[4*i +: 4];
                if (carry) begin
                    if (bus.up) begin
                        if (dig >= 4'd9) begin
                            bcd_d[4*i +: 4] = 4'd0;
                        end else begin
                            bcd_d[4*i +: 4] = dig + 4'd1;
                            carry           = 1'b0;
                        end
                    end else begin
                        if (dig == 4'd0) begin
                            bcd_d[4*i +: 4] = 4'd9;
                        end else begin
                            bcd_d[4*i +: 4] = dig - 4'd1;
                            carry           = 1'b0;
                        end
                    end
                end
            end
            wrap_d = carry;
        end
    end

    // Scan runs free of en so the display never stalls.
    always_comb begin
        ref_d = (ref_q == RLAST) ? '0 : ref_q + 1'b1;
        idx_d = idx_q;
        if (ref_q == RLAST) begin
            idx_d = (idx_q == ILAST) ? '0 : idx_q + 1'b1;
        end
    end

    always_comb begin
        logic [3:0] cur;
        cur  = '0;
        an_d = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur     = bcd_q[4*i +: 4];
                an_d[i] = 1'b0;
            end
        end
        seg_d = seg_code(cur);
`ifdef FND_LZB_EN
        begin
            logic lead;
            lead = 1'b1;
            // Walk down from the top digit; lead stays set while every digit so far is zero.
            for (int i = NUM_DIGITS - 1; i > 0; i--) begin
                lead = lead & (bcd_q[4*i +: 4] == 4'd0);
                if (lead && (idx_q == IW'(i))) begin
                    seg_d = 7'b1111111;
                end
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            bcd_q   <= '0;
            wrap_q  <= 1'b0;
            ref_q   <= '0;
            idx_q   <= '0;
            an_q    <= '1;
            seg_q   <= 7'b1111111;
        end else begin
            presc_q <= presc_d;
            bcd_q   <= bcd_d;
            wrap_q  <= wrap_d;
            ref_q   <= ref_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign bus.bcd_value = bcd_q;
    assign bus.wrap      = wrap_q;
    assign seg           = seg_q;
    assign an            = an_q;
endmodule
